// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: word type, fetch FSM states and PC constants.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_STEP  = 32'd4;
  // Upper PC bits carried over into J/JAL targets.
  localparam int    JADDR_HI = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus between the fetch stage and instruction memory.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  ihit;
  word_t iload;

  modport master (
    output iREN,
    output iaddr,
    input  ihit,
    input  iload
  );

  modport slave (
    input  iREN,
    input  iaddr,
    output ihit,
    output iload
  );

endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: sequential, branch, jump and register-jump targets.
module next_pc_sel
  import cpu_types_pkg::*;
(
  input  word_t       pc,
  input  word_t       rs_data,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic        JR,
  input  logic        Jmp,
  input  logic        JAL,
  input  logic        PCSrc,
  output word_t       next_pc,
  output word_t       pc_plus4
);

  word_t branch_off;
  word_t branch_target;
  word_t jump_target;

  assign pc_plus4      = pc + PC_STEP;
  assign branch_off    = {{14{imm16[15]}}, imm16, 2'b00};
  assign branch_target = pc_plus4 + branch_off;
  assign jump_target   = {pc_plus4[31:32-JADDR_HI], imm26, 2'b00};

  // Register jump outranks absolute jumps, which outrank taken branches.
  always_comb begin
    next_pc = pc_plus4;
    if (JR) begin
      next_pc = rs_data;
    end else if (Jmp || JAL) begin
      next_pc = jump_target;
    end else if (PCSrc) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake, instruction register and halt latch.
// Optional FETCH_PERF_CNT_EN adds cycle_cnt / instr_cnt performance counters.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         n_rst,
  fetch_unit_if.master imem,
  input  logic         advance,
  input  logic         PCSrc,
  input  logic         Jmp,
  input  logic         JAL,
  input  logic         JR,
  input  logic         Halt,
  input  logic [15:0]  imm16,
  input  logic [25:0]  imm26,
  input  word_t        rs_data,
  output word_t        Instr,
  output logic         instr_valid,
  output word_t        pc,
  output word_t        pc_plus4,
`ifdef FETCH_PERF_CNT_EN
  output word_t        cycle_cnt,
  output word_t        instr_cnt,
`endif
  output logic         halted
);

  fetch_state_t state_reg, state_next;
  word_t        pc_reg, pc_next;
  word_t        instr_reg, instr_next;
  word_t        next_pc;
  logic         iren_next;

  next_pc_sel u_next_pc_sel (
    .pc       (pc_reg),
    .rs_data  (rs_data),
    .imm16    (imm16),
    .imm26    (imm26),
    .JR       (JR),
    .Jmp      (Jmp),
    .JAL      (JAL),
    .PCSrc    (PCSrc),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_reg <= FETCH;
      pc_reg    <= PC_INIT;
      instr_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    iren_next   = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_reg)
      FETCH: begin
        iren_next = 1'b1;
        if (imem.ihit) begin
          instr_next = imem.iload;
          state_next = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        // Halt takes precedence so a halting instruction never redirects the PC.
        if (Halt) begin
          state_next = HALTED;
        end else if (advance) begin
          pc_next    = next_pc;
          state_next = FETCH;
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign imem.iREN  = iren_next;
  assign imem.iaddr = pc_reg;
  assign pc         = pc_reg;
  assign Instr      = instr_reg;

`ifdef FETCH_PERF_CNT_EN
  word_t cycle_cnt_reg;
  word_t instr_cnt_reg;

  // The halting instruction counts as retired on its way into HALTED.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      cycle_cnt_reg <= '0;
      instr_cnt_reg <= '0;
    end else if (state_reg != HALTED) begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (state_reg == EXEC && (Halt || advance)) begin
        instr_cnt_reg <= instr_cnt_reg + 32'd1;
      end
    end
  end

  assign cycle_cnt = cycle_cnt_reg;
  assign instr_cnt = instr_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit; expected values are hand-computed constants.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic        clk;
  logic        n_rst;
  logic        advance, PCSrc, Jmp, JAL, JR, Halt;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_data;
  logic [31:0] Instr, pc, pc_plus4;
  logic        instr_valid, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int vec_cnt;
  int err_cnt;

  fetch_unit_if imem_bus ();

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .imem        (imem_bus),
    .advance     (advance),
    .PCSrc       (PCSrc),
    .Jmp         (Jmp),
    .JAL         (JAL),
    .JR          (JR),
    .Halt        (Halt),
    .imm16       (imm16),
    .imm26       (imm26),
    .rs_data     (rs_data),
    .Instr       (Instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
`ifdef FETCH_PERF_CNT_EN
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt),
`endif
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    advance = 1'b0; PCSrc = 1'b0; Jmp = 1'b0; JAL = 1'b0; JR = 1'b0; Halt = 1'b0;
    imm16 = '0; imm26 = '0; rs_data = '0;
    imem_bus.ihit = 1'b0; imem_bus.iload = '0;
  endtask

  task automatic fetch_word(input logic [31:0] w);
    imem_bus.ihit = 1'b1; imem_bus.iload = w;
    tick();
    imem_bus.ihit = 1'b0; imem_bus.iload = '0;
  endtask

  task automatic retire();
    advance = 1'b1;
    tick();
    clear_ctrl();
  endtask

  task automatic jump_to(input logic [31:0] a);
    fetch_word(32'h0000_0008);
    JR = 1'b1; rs_data = a;
    retire();
  endtask

  task automatic do_reset();
    n_rst = 1'b1;
    tick();
    tick();
    n_rst = 1'b0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    clear_ctrl();
    do_reset();

    check_vec("rst_pc", pc, 32'h0);
    check_vec("rst_instr", Instr, 32'h0);
    check_vec("rst_valid", instr_valid, 32'h0);
    check_vec("rst_halted", halted, 32'h0);
    check_vec("rst_iren", imem_bus.iREN, 32'h1);
    check_vec("rst_iaddr", imem_bus.iaddr, 32'h0);

    // First fetch and sequential retire
    fetch_word(32'h2008_0005);
    check_vec("f1_instr", Instr, 32'h2008_0005);
    check_vec("f1_valid", instr_valid, 32'h1);
    check_vec("f1_iren", imem_bus.iREN, 32'h0);
    check_vec("f1_pc", pc, 32'h0);
    imem_bus.ihit = 1'b1; imem_bus.iload = 32'hBAD0_BAD0;
    tick();
    imem_bus.ihit = 1'b0;
    check_vec("exec_ignores_ihit", Instr, 32'h2008_0005);
    retire();
    check_vec("seq_pc", pc, 32'h4);
    check_vec("seq_iren", imem_bus.iREN, 32'h1);
    check_vec("seq_iaddr", imem_bus.iaddr, 32'h4);
    check_vec("seq_valid", instr_valid, 32'h0);

    // Branches backward and forward from 0x40
    jump_to(32'h40);
    check_vec("jr_to_40", pc, 32'h40);
    fetch_word(32'h1000_FFFE);
    PCSrc = 1'b1; imm16 = 16'hFFFE;
    retire();
    check_vec("br_back", pc, 32'h3C);
    jump_to(32'h40);
    fetch_word(32'h1000_0003);
    PCSrc = 1'b1; imm16 = 16'h0003;
    retire();
    check_vec("br_fwd", pc, 32'h50);

    // JAL keeps upper PC bits; JR beats Jmp
    jump_to(32'h1000_0008);
    fetch_word(32'h0C00_0010);
    JAL = 1'b1; imm26 = 26'h000_0010;
    #1;
    check_vec("jal_link", pc_plus4, 32'h1000_000C);
    retire();
    check_vec("jal_pc", pc, 32'h1000_0040);
    fetch_word(32'h0360_0008);
    JR = 1'b1; Jmp = 1'b1; rs_data = 32'h80; imm26 = 26'h3FF_FFFF;
    retire();
    check_vec("jr_prio", pc, 32'h80);

    // FETCH stall, then reset arriving with ihit
    for (int i = 0; i < 2; i++) begin
      tick();
      check_vec("stall_iren", imem_bus.iREN, 32'h1);
      check_vec("stall_iaddr", imem_bus.iaddr, 32'h80);
    end
    n_rst = 1'b1; imem_bus.ihit = 1'b1; imem_bus.iload = 32'hDEAD_BEEF;
    tick();
    n_rst = 1'b0; imem_bus.ihit = 1'b0; imem_bus.iload = '0;
    check_vec("rst_ihit_instr", Instr, 32'h0);
    check_vec("rst_ihit_pc", pc, 32'h0);
    check_vec("rst_ihit_valid", instr_valid, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_vec("stall2_iren", imem_bus.iREN, 32'h1);
      check_vec("stall2_iaddr", imem_bus.iaddr, 32'h0);
    end

    // Reset mid-EXEC overrides advance
    jump_to(32'h200);
    fetch_word(32'h1234_5678);
    n_rst = 1'b1; advance = 1'b1;
    tick();
    n_rst = 1'b0; advance = 1'b0;
    check_vec("rst_exec_pc", pc, 32'h0);
    check_vec("rst_exec_iren", imem_bus.iREN, 32'h1);

    // PC wraparound
    jump_to(32'hFFFF_FFFC);
    fetch_word(32'h0000_0000);
    #1;
    check_vec("wrap_plus4", pc_plus4, 32'h0);
    retire();
    check_vec("wrap_pc", pc, 32'h0);

    // Three retirements then halt with a simultaneous advance
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fetch_word(32'h2000_0000 + 32'(i));
      retire();
    end
    fetch_word(32'hFFFF_FFFF);
    Halt = 1'b1; advance = 1'b1; JR = 1'b1; rs_data = 32'h500;
    tick();
    clear_ctrl();
    check_vec("halt_halted", halted, 32'h1);
    check_vec("halt_iren", imem_bus.iREN, 32'h0);
    check_vec("halt_valid", instr_valid, 32'h0);
    check_vec("halt_pc", pc, 32'hC);
`ifdef FETCH_PERF_CNT_EN
    check_vec("instr_cnt", instr_cnt, 32'd4);
    check_vec("cycle_cnt", cycle_cnt, 32'd8);
`endif
    for (int i = 0; i < 3; i++) begin
      imem_bus.ihit = 1'b1; imem_bus.iload = 32'h1111_1111; advance = 1'b1;
      tick();
      clear_ctrl();
      tick();
      check_vec("halt_hold_pc", pc, 32'hC);
      check_vec("halt_hold_instr", Instr, 32'hFFFF_FFFF);
      check_vec("halt_hold_iren", imem_bus.iREN, 32'h0);
      check_vec("halt_hold_flag", halted, 32'h1);
    end
`ifdef FETCH_PERF_CNT_EN
    check_vec("instr_cnt_frozen", instr_cnt, 32'd4);
    check_vec("cycle_cnt_frozen", cycle_cnt, 32'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
